key_debounce_ctrl: RTL and testbench
====================================

Name: key_debounce_ctrl

Overview:
Debounce controller for one mechanical key input. It synchronises the raw asynchronous key, filters bounce with a press/release state machine and counters, and issues single-cycle press, release and long-press events plus a stable level. It sits between board key pins and user logic, one instance per key.

Parameters:
DEBOUNCE_CNT, 1000000, stable cycles required to accept a press or a release (20 ms at 50 MHz); must be at least 2.
LONG_CNT, 50000000, cycles held in HELD before key_long fires (1 s at 50 MHz); must be at least 2.
CNT_W, 26, width of both counters; must satisfy 2^CNT_W > max(DEBOUNCE_CNT, LONG_CNT).
ACTIVE_LOW, 1, 1 = pressed key drives key_in low; 0 = pressed drives high.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  controller enable; 0 forces the FSM to IDLE
key_in  in  1  raw asynchronous key pin
key_press  out  1  one-cycle pulse when a press is accepted
key_release  out  1  one-cycle pulse when a release is accepted
key_long  out  1  one-cycle pulse, once per press, after LONG_CNT held cycles
key_level  out  1  debounced pressed level

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (rst) and has priority over everything else.
- Reset values:
  - all outputs 0; state IDLE; cnt 0; hold_cnt 0; long_done 0.
  - both synchroniser flops reset to the inactive pin level (1 if ACTIVE_LOW, else 0).
- Synchroniser:
  - 2-flop chain on key_in, sync0 then sync1.
  - key_act = sync1 XOR ACTIVE_LOW, i.e. 1 means pressed.
  - The chain always runs, including when en = 0.
- en = 0: state goes to IDLE on the next edge; cnt, hold_cnt and long_done clear; all outputs 0; no release pulse is issued.
- FSM (2-bit state):
  - IDLE: if key_act, go to DOWN_FILT with cnt = 0.
  - DOWN_FILT: if not key_act, go to IDLE and clear cnt (bounce rejected). Else if cnt == DEBOUNCE_CNT-1, go to HELD, assert key_press, and clear hold_cnt and long_done. Else increment cnt.
  - HELD: if not key_act, go to UP_FILT with cnt = 0. Otherwise, if long_done = 0, increment hold_cnt. When hold_cnt == LONG_CNT-1 and long_done = 0, assert key_long, set long_done and hold hold_cnt saturated.
  - UP_FILT: if key_act, return to HELD (bounce rejected); hold_cnt and long_done are kept, not reset. Else if cnt == DEBOUNCE_CNT-1, go to IDLE and assert key_release. Else increment cnt. hold_cnt is frozen in UP_FILT.
- key_level is 1 in HELD and UP_FILT, 0 in IDLE and DOWN_FILT. All outputs are registered.
- Press latency: count the first edge that samples an active key_in as edge 0.
  - key_act is visible after edge 1.
  - DOWN_FILT is entered at edge 2.
  - key_press and key_level rise after edge DEBOUNCE_CNT+2.
- Release latency is symmetric: key_release is high after edge DEBOUNCE_CNT+2 relative to the first sampled inactive level, and key_level falls on that same edge.
- Pulse rules:
  - key_press, key_release and key_long are each exactly 1 cycle wide.
  - key_long fires at most once per accepted press.
  - key_press and key_release never assert in the same cycle.
- Reset or en = 0 mid-press: the press is abandoned with no release pulse.

Decomposition:
- Package key_debounce_pkg holds:
  - state encodings: IDLE = 2'd0, DOWN_FILT = 2'd1, HELD = 2'd2, UP_FILT = 2'd3.
  - default count constants for a 50 MHz clock.
- Sub-module key_sync2 contains the 2-flop synchroniser with synchronous active-high reset and a parameterised reset level. The FSM and counters stay in key_debounce_ctrl.

Test Plan:
All scenarios use DEBOUNCE_CNT = 4, LONG_CNT = 10, ACTIVE_LOW = 1.
1. Clean press: key_in held 1 then driven to 0 and held -> key_press is a 1-cycle pulse after edge 6 and key_level = 1 from then on; no other pulse.
2. Press bounce: key_in low for 3 cycles, high for 2, then low and held -> no key_press during the glitch; key_press fires 6 edges after the final falling sample.
3. Clean release after a press: key_in returns to 1 -> key_release is a 1-cycle pulse 6 edges later and key_level = 0; a 2-cycle high glitch during release gives no release and key_level stays 1.
4. Long press: hold pressed for 30 cycles after key_press -> exactly one key_long, 10 cycles after key_press; a 2-cycle release bounce inside the hold does not retrigger key_long.
5. Synchronous reset or en = 0 while in HELD -> all outputs 0 on the next edge, no key_release; a subsequent press needs the full 6-edge latency again.
6. key_in held active through reset deassertion -> key_press 6 edges after the first post-reset edge.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared state encoding and 50 MHz default timing constants for the key debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DOWN_FILT = 2'd1,
        HELD      = 2'd2,
        UP_FILT   = 2'd3
    } key_state_e;

    localparam int unsigned DEF_DEBOUNCE_CNT = 1000000;   // 20 ms at 50 MHz
    localparam int unsigned DEF_LONG_CNT     = 50000000;  // 1 s at 50 MHz
    localparam int unsigned DEF_CNT_W        = 26;

    function automatic logic is_pressed_state(input key_state_e s);
        return (s == HELD) || (s == UP_FILT);
    endfunction

endpackage

// File: rtl/key_debounce_ctrl_sync.sv
// Two-flop synchroniser for an asynchronous pin; reset loads a configurable idle level.
module key_sync2 #(
    parameter bit RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync0_q, sync0_d;
    logic sync1_q, sync1_d;

    always_comb begin
        sync0_d = d;
        sync1_d = sync0_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= RST_VAL;
            sync1_q <= RST_VAL;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
        end
    end

    assign q = sync1_q;

endmodule

// File: rtl/key_debounce_ctrl.sv
// Single-key debounce controller: synchronised input, press/release filter FSM,
// and registered press, release, long-press pulses plus a debounced level.
module key_debounce_ctrl
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int unsigned LONG_CNT     = DEF_LONG_CNT,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic key_in,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_level
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

    logic       sync_key;
    logic       key_act;

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             long_done_q, long_done_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             level_q, level_d;

    key_sync2 #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_in),
        .q   (sync_key)
    );

    assign key_act = sync_key ^ ACTIVE_LOW;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        if (!en) begin
            state_d     = IDLE;
            cnt_d       = '0;
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_act) begin
                        state_d = DOWN_FILT;
                        cnt_d   = '0;
                    end
                end
                DOWN_FILT: begin
                    if (!key_act) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d     = HELD;
                        cnt_d       = '0;
                        press_d     = 1'b1;
                        hold_cnt_d  = '0;
                        long_done_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!key_act) begin
                        state_d = UP_FILT;
                        cnt_d   = '0;
                    end else if (!long_done_q) begin
                        // hold_cnt saturates at LONG_LAST; long_done blocks re-firing
                        if (hold_cnt_q == LONG_LAST) begin
                            long_d      = 1'b1;
                            long_done_d = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                UP_FILT: begin
                    if (key_act) begin
                        state_d = HELD;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        level_d = is_pressed_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            level_q     <= level_d;
        end
    end

    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_level   = level_q;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Scoreboard bench for key_debounce_ctrl with DEBOUNCE_CNT=4, LONG_CNT=10, active-low key.
module tb_key_debounce_ctrl;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;

    typedef struct {
        int   kind;
        int   cyc;
        logic lvl;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic key_in;
    logic key_press;
    logic key_release;
    logic key_long;
    logic key_level;

    int   cyc = 0;
    int   checks = 0;
    int   bad = 0;
    ev_t  exp_q[$];

    key_debounce_ctrl #(
        .DEBOUNCE_CNT (4),
        .LONG_CNT     (10),
        .CNT_W        (8),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .key_in      (key_in),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_level   (key_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input int c, input logic lvl);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.lvl  = lvl;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic lvl);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got kind=%0d cyc=%0d lvl=%0b want none", kind, cyc, lvl);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.lvl !== lvl) begin
                bad++;
                $display("FAIL event got kind=%0d cyc=%0d lvl=%0b want kind=%0d cyc=%0d lvl=%0b",
                         kind, cyc, lvl, e.kind, e.cyc, e.lvl);
            end
        end
    endtask

    // Monitor: every pulse seen must match the head of the expected-event queue.
    always @(negedge clk) begin
        if (key_press)   check_ev(EV_PRESS, key_level);
        if (key_release) check_ev(EV_RELEASE, key_level);
        if (key_long)    check_ev(EV_LONG, key_level);
    end

    task automatic chk(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0b want=%0b cyc=%0d", name, act, want, cyc);
        end
    endtask

    task automatic drive(input logic v, output int t);
        @(negedge clk);
        key_in = v;
        t = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        int t, g, r, d;
        rst = 1'b1;
        en = 1'b1;
        key_in = 1'b1;
        idle(3);
        chk("reset_press", key_press, 1'b0);
        chk("reset_release", key_release, 1'b0);
        chk("reset_long", key_long, 1'b0);
        chk("reset_level", key_level, 1'b0);
        rst = 1'b0;
        idle(4);
        chk("idle_level", key_level, 1'b0);

        // Clean press, held long enough for a single long-press, with a mid-hold bounce.
        drive(1'b0, t);
        push(EV_PRESS, t + 7, 1'b1);
        push(EV_LONG, t + 17, 1'b1);
        wait_until(t + 9);
        chk("press_level", key_level, 1'b1);
        wait_until(t + 20);
        drive(1'b1, d);
        idle(1);
        drive(1'b0, d);
        wait_until(t + 37);
        chk("hold_bounce_level", key_level, 1'b1);

        // Two-cycle high glitch during release, then a clean release.
        drive(1'b1, g);
        idle(1);
        drive(1'b0, d);
        wait_until(g + 4);
        chk("release_glitch_level", key_level, 1'b1);
        wait_until(g + 10);
        drive(1'b1, t);
        push(EV_RELEASE, t + 7, 1'b0);
        wait_until(t + 10);
        chk("release_level", key_level, 1'b0);

        // Press bounce: 3 low, 2 high, then low and held.
        drive(1'b0, d);
        idle(2);
        drive(1'b1, d);
        idle(1);
        drive(1'b0, t);
        push(EV_PRESS, t + 7, 1'b1);
        wait_until(t + 10);
        chk("bounce_press_level", key_level, 1'b1);

        // Reset in HELD with the key still down: no release, full latency afterwards.
        @(negedge clk);
        rst = 1'b1;
        r = cyc;
        @(negedge clk);
        chk("rst_held_level", key_level, 1'b0);
        rst = 1'b0;
        push(EV_PRESS, r + 8, 1'b1);
        push(EV_LONG, r + 18, 1'b1);
        wait_until(r + 22);
        chk("post_rst_level", key_level, 1'b1);

        // en low in HELD: outputs drop, no release; a later press needs full latency.
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_level", key_level, 1'b0);
        drive(1'b1, d);
        idle(6);
        en = 1'b1;
        idle(3);
        chk("en_on_idle_level", key_level, 1'b0);
        drive(1'b0, t);
        push(EV_PRESS, t + 7, 1'b1);
        push(EV_LONG, t + 17, 1'b1);
        wait_until(t + 20);
        drive(1'b1, t);
        push(EV_RELEASE, t + 7, 1'b0);
        wait_until(t + 12);
        chk("final_level", key_level, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events got pending=%0d want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
